// File: rtl/pmu_pkg.sv
// pmu_pkg: shared types and constants for the performance-monitor controller.
//   pmu_state_e : controller FSM states (value equals the CTRL[1:0] read encoding)
//   pmu_ev_e    : event / counter index (EV_CYCLE..EV_MISP)
//   OFF_*       : register byte offsets on the LSU peripheral port
//   CTRL_*      : CTRL register bit positions
package pmu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FROZEN = 2'd2
  } pmu_state_e;

  typedef enum logic [1:0] {
    EV_CYCLE = 2'd0,
    EV_INSN  = 2'd1,
    EV_CTRL  = 2'd2,
    EV_MISP  = 2'd3
  } pmu_ev_e;

  localparam int NUM_EV = 4;

  localparam logic [5:0] OFF_CTRL    = 6'h00;
  localparam logic [5:0] OFF_STATUS  = 6'h04;
  localparam logic [5:0] OFF_CYCLE   = 6'h10;
  localparam logic [5:0] OFF_INSN    = 6'h18;
  localparam logic [5:0] OFF_CTRLCNT = 6'h20;
  localparam logic [5:0] OFF_MISP    = 6'h28;

  localparam int CTRL_START   = 0;
  localparam int CTRL_STOP    = 1;
  localparam int CTRL_CLEAR   = 2;
  localparam int CTRL_SNAP    = 3;
  localparam int CTRL_IRQ_LSB = 4;

endpackage

// File: rtl/pmu_ctrl_if.sv
// pmu_ctrl_if: memory-mapped register port of the PMU.
//   pmu_we/pmu_re   : write / read strobes (may assert together)
//   pmu_addr        : byte address, [1:0] ignored
//   pmu_wdata       : write data
//   pmu_rdata       : registered read data
//   pmu_rvalid      : one-cycle pulse, one cycle after pmu_re
interface pmu_ctrl_if;
  logic        pmu_we;
  logic        pmu_re;
  logic [5:0]  pmu_addr;
  logic [31:0] pmu_wdata;
  logic [31:0] pmu_rdata;
  logic        pmu_rvalid;

  modport master (output pmu_we, pmu_re, pmu_addr, pmu_wdata,
                  input  pmu_rdata, pmu_rvalid);
  modport slave  (input  pmu_we, pmu_re, pmu_addr, pmu_wdata,
                  output pmu_rdata, pmu_rvalid);
endinterface

// File: rtl/pmu_counter.sv
// pmu_counter: one live event counter plus its snapshot register.
//   clk_i, rst_ni : clock, async active-low reset
//   inc_i         : add one this cycle
//   clr_i         : zero the live counter (beats inc_i)
//   snap_i        : copy the pre-increment live value into the snapshot
//   live_o        : live count
//   snap_o        : snapshot
//   ovf_o         : pulse when an increment wraps all-ones to zero
module pmu_counter #(
  parameter int CNT_W = 64
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  input  logic             clr_i,
  input  logic             snap_i,
  output logic [CNT_W-1:0] live_o,
  output logic [CNT_W-1:0] snap_o,
  output logic             ovf_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d, snap_q, snap_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)      cnt_d = '0;
    else if (inc_i) cnt_d = cnt_q + CNT_W'(1);
    // snapshot always sees the value before this cycle's clear/increment
    snap_d = snap_i ? cnt_q : snap_q;
  end

  // a clear in the same cycle suppresses the wrap, so no flag either
  assign ovf_o  = inc_i & ~clr_i & (&cnt_q);
  assign live_o = cnt_q;
  assign snap_o = snap_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      snap_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      snap_q <= snap_d;
    end
  end
endmodule

// File: rtl/pmu_ctrl.sv
// pmu_ctrl: performance-monitor controller. Counts cycles, retired instructions,
// control transfers and mispredictions while in RUN; software controls it through
// the register port. Counter reads always return snapshot registers.
//   i_clk, i_reset          : core clock, async active-low reset
//   i_insn_vld/i_ctrl/i_mispred : pipeline retire strobes
//   bus (pmu_ctrl_if.slave) : register port
//   o_pmu_running           : high in RUN
//   o_pmu_irq               : overflow interrupt
// Build option: PMU_IRQ_EN enables the stored IRQ_EN field and the registered
// interrupt; without it IRQ_EN reads 0 and o_pmu_irq is tied low.
module pmu_ctrl
  import pmu_pkg::*;
#(
  parameter int CNT_W = 64
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_insn_vld,
  input  logic       i_ctrl,
  input  logic       i_mispred,
  pmu_ctrl_if.slave  bus,
  output logic       o_pmu_running,
  output logic       o_pmu_irq
);
  pmu_state_e state_q, state_d;
  logic [5:0] waddr;
  logic wr_ctrl, wr_status;
  logic cmd_start, cmd_stop, cmd_clear, cmd_snap;
  logic run, frz_snap_q, snap_any;
  logic [NUM_EV-1:0] inc, ovf_p;
  logic [3:0] ovf_q, ovf_d, w1c, irq_en;
  logic [NUM_EV-1:0][CNT_W-1:0] live_w, snap_w;
  logic [NUM_EV-1:0][63:0] snap_ext;
  logic [31:0] rd_d, rdata_q;
  logic rvalid_q;

  assign waddr     = {bus.pmu_addr[5:2], 2'b00};
  assign wr_ctrl   = bus.pmu_we && (waddr == OFF_CTRL);
  assign wr_status = bus.pmu_we && (waddr == OFF_STATUS);
  assign cmd_start = wr_ctrl & bus.pmu_wdata[CTRL_START];
  assign cmd_stop  = wr_ctrl & bus.pmu_wdata[CTRL_STOP];
  assign cmd_clear = wr_ctrl & bus.pmu_wdata[CTRL_CLEAR];
  assign cmd_snap  = wr_ctrl & bus.pmu_wdata[CTRL_SNAP];

  // STOP dominates START in every state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_FROZEN: if (cmd_start && !cmd_stop) state_d = ST_RUN;
      ST_RUN:             if (cmd_stop) state_d = ST_FROZEN;
      default:            state_d = ST_IDLE;
    endcase
  end

  assign run           = (state_q == ST_RUN);
  assign o_pmu_running = run;

  // The freeze snapshot is taken one cycle after the STOP edge so that it
  // includes the STOP cycle's own increment; counters are frozen by then.
  assign snap_any = cmd_snap | frz_snap_q;

  assign inc[EV_CYCLE] = run;
  assign inc[EV_INSN]  = run & i_insn_vld;
  assign inc[EV_CTRL]  = run & i_insn_vld & i_ctrl;
  assign inc[EV_MISP]  = run & i_insn_vld & i_ctrl & i_mispred;

  for (genvar g = 0; g < NUM_EV; g++) begin : g_ev
    pmu_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk_i  (i_clk),
      .rst_ni (i_reset),
      .inc_i  (inc[g]),
      .clr_i  (cmd_clear),
      .snap_i (snap_any),
      .live_o (live_w[g]),
      .snap_o (snap_w[g]),
      .ovf_o  (ovf_p[g])
    );
    assign snap_ext[g] = 64'(snap_w[g]);
  end

  // set beats a same-edge write-one-to-clear
  assign w1c   = wr_status ? bus.pmu_wdata[3:0] : 4'h0;
  assign ovf_d = (ovf_q & ~w1c) | ovf_p;

`ifdef PMU_IRQ_EN
  logic [3:0] irq_en_q;
  logic       irq_q;
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      irq_en_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      if (wr_ctrl) irq_en_q <= bus.pmu_wdata[CTRL_IRQ_LSB +: 4];
      irq_q <= |(ovf_q & irq_en_q);
    end
  end
  assign irq_en    = irq_en_q;
  assign o_pmu_irq = irq_q;
`else
  assign irq_en    = 4'h0;
  assign o_pmu_irq = 1'b0;
`endif

  always_comb begin
    rd_d = '0;
    if (waddr == OFF_CTRL) begin
      rd_d[1:0] = state_q;
      rd_d[7:4] = irq_en;
    end else if (waddr == OFF_STATUS) begin
      rd_d[3:0] = ovf_q;
    end else begin
      for (int e = 0; e < NUM_EV; e++)
        if (waddr[5:3] == OFF_CYCLE[5:3] + 3'(e))
          rd_d = waddr[2] ? snap_ext[e][63:32] : snap_ext[e][31:0];
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= ST_IDLE;
      frz_snap_q <= 1'b0;
      ovf_q      <= '0;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      frz_snap_q <= run && (state_d == ST_FROZEN);
      ovf_q      <= ovf_d;
      rvalid_q   <= bus.pmu_re;
      if (bus.pmu_re) rdata_q <= rd_d;
    end
  end

  assign bus.pmu_rdata  = rdata_q;
  assign bus.pmu_rvalid = rvalid_q;

  logic unused_bits;
  assign unused_bits = ^{bus.pmu_addr[1:0], bus.pmu_wdata[31:4], live_w};
endmodule

// File: tb/tb_pmu_ctrl.sv
// tb_pmu_ctrl: directed bench for pmu_ctrl (CNT_W=32). Inputs change on the
// falling edge, outputs are checked on the falling edge.
module tb_pmu_ctrl;
  import pmu_pkg::*;
  localparam int CW = 32;
`ifdef PMU_IRQ_EN
  localparam logic IRQ = 1'b1;
`else
  localparam logic IRQ = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b0;
  logic insn = 1'b0, ctl = 1'b0, misp = 1'b0;
  logic running, irq;
  int n_chk = 0, n_err = 0;

  pmu_ctrl_if bus ();

  pmu_ctrl #(.CNT_W(CW)) dut (
    .i_clk         (clk),
    .i_reset       (rst_n),
    .i_insn_vld    (insn),
    .i_ctrl        (ctl),
    .i_mispred     (misp),
    .bus           (bus),
    .o_pmu_running (running),
    .o_pmu_irq     (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // all tasks start and end on a falling edge
  task automatic wr(input logic [5:0] a, input logic [31:0] d);
    bus.pmu_we = 1'b1; bus.pmu_addr = a; bus.pmu_wdata = d;
    @(negedge clk);
    bus.pmu_we = 1'b0; bus.pmu_wdata = '0;
  endtask

  task automatic rd(input logic [5:0] a, input logic [31:0] exp, input string tag);
    bus.pmu_re = 1'b1; bus.pmu_addr = a;
    @(negedge clk);
    bus.pmu_re = 1'b0;
    chk(tag, bus.pmu_rdata, exp);
    chk({tag, "_rv"}, {31'd0, bus.pmu_rvalid}, 32'd1);
    @(negedge clk);
    chk({tag, "_rvpulse"}, {31'd0, bus.pmu_rvalid}, 32'd0);
  endtask

  task automatic strobes(input int n, input int nctl, input int nmisp);
    for (int i = 0; i < n; i++) begin
      insn = 1'b1; ctl = (i < nctl); misp = (i < nmisp);
      @(negedge clk);
    end
    insn = 1'b0; ctl = 1'b0; misp = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.pmu_we = 1'b0; bus.pmu_re = 1'b0; bus.pmu_addr = '0; bus.pmu_wdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_rdata",   bus.pmu_rdata, 32'd0);
    chk("rst_rvalid",  {31'd0, bus.pmu_rvalid}, 32'd0);
    chk("rst_running", {31'd0, running}, 32'd0);
    chk("rst_irq",     {31'd0, irq}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: idle reads
    rd(OFF_CTRL, 32'd0, "t1_ctrl");
    rd(OFF_CYCLE, 32'd0, "t1_cycle");
    rd(6'h08, 32'd0, "t1_unmapped08");
    rd(6'h30, 32'd0, "t1_unmapped30");
    chk("t1_running", {31'd0, running}, 32'd0);

    // 2: 10 insns (3 ctrl, 1 misp) then STOP; cycles = 10 strobe + STOP cycle
    wr(OFF_CTRL, 32'h1);
    chk("t2_running", {31'd0, running}, 32'd1);
    strobes(10, 3, 1);
    wr(OFF_CTRL, 32'h2);
    repeat (2) @(negedge clk);
    chk("t2_stopped", {31'd0, running}, 32'd0);
    rd(OFF_CTRL, 32'd2, "t2_state_frozen");
    rd(OFF_INSN, 32'd10, "t2_insn");
    rd(OFF_CTRLCNT, 32'd3, "t2_ctrl");
    rd(OFF_MISP, 32'd1, "t2_misp");
    rd(OFF_CYCLE, 32'd11, "t2_cycle");
    rd(OFF_CYCLE + 6'h4, 32'd0, "t2_cycle_hi");

    // 3: strobes while frozen are ignored; resume adds 4 insns, 5 cycles
    strobes(5, 5, 5);
    wr(OFF_CTRL, 32'h1);
    strobes(4, 0, 0);
    wr(OFF_CTRL, 32'h2);
    repeat (2) @(negedge clk);
    rd(OFF_INSN, 32'd14, "t3_insn");
    rd(OFF_CYCLE, 32'd16, "t3_cycle");
    rd(OFF_MISP, 32'd1, "t3_misp");

    // reset in the middle of a run
    wr(OFF_CTRL, 32'h1);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_running", {31'd0, running}, 32'd0);
    chk("mid_rst_rdata", bus.pmu_rdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rd(OFF_CYCLE, 32'd0, "mid_rst_cycle");
    rd(OFF_INSN, 32'd0, "mid_rst_insn");

    // 5: START|STOP from IDLE stays IDLE
    wr(OFF_CTRL, 32'h3);
    rd(OFF_CTRL, 32'd0, "t5_startstop_idle");
    // simultaneous read+START returns pre-write state
    bus.pmu_we = 1'b1; bus.pmu_re = 1'b1; bus.pmu_addr = OFF_CTRL; bus.pmu_wdata = 32'h1;
    @(negedge clk);
    bus.pmu_we = 1'b0; bus.pmu_re = 1'b0; bus.pmu_wdata = '0;
    chk("t5_rw_prewrite", bus.pmu_rdata, 32'd0);
    chk("t5_rw_running", {31'd0, running}, 32'd1);
    strobes(6, 0, 0);
    wr(OFF_CTRL, 32'hC);                 // CLEAR|SNAP
    rd(OFF_INSN, 32'd6, "t5_snap_insn");
    rd(OFF_CYCLE, 32'd6, "t5_snap_cycle");
    strobes(3, 0, 0);
    wr(OFF_CTRL, 32'h2);
    repeat (2) @(negedge clk);
    rd(OFF_INSN, 32'd3, "t5_restart_insn");

    // 4/6: cycle counter wrap, STATUS W1C, IRQ
    wr(OFF_CTRL, 32'h11);                // START, IRQ_EN=1
    force dut.g_ev[0].u_cnt.cnt_q = 32'hFFFF_FFFE;
    #1 release dut.g_ev[0].u_cnt.cnt_q;
    repeat (2) @(negedge clk);           // wrap on the second edge
    chk("t6_irq_latency", {31'd0, irq}, 32'd0);
    @(negedge clk);
    chk("t6_irq_set", {31'd0, irq}, {31'd0, IRQ});
    rd(OFF_STATUS, 32'h1, "t4_status_set");
    // W1C on the same edge as a new wrap: flag stays set
    force dut.g_ev[0].u_cnt.cnt_q = 32'hFFFF_FFFF;
    #1 release dut.g_ev[0].u_cnt.cnt_q;
    wr(OFF_STATUS, 32'h1);
    rd(OFF_STATUS, 32'h1, "t4_w1c_vs_set");
    wr(OFF_CTRL, 32'h2);
    repeat (2) @(negedge clk);
    rd(OFF_CYCLE, 32'd3, "t4_cycle_wrapped");
    rd(OFF_CTRL, IRQ ? 32'h12 : 32'h02, "t6_ctrl_irqen");
    wr(OFF_STATUS, 32'h1);
    chk("t6_irq_hold", {31'd0, irq}, {31'd0, IRQ});
    @(negedge clk);
    chk("t6_irq_clr", {31'd0, irq}, 32'd0);
    rd(OFF_STATUS, 32'h0, "t4_status_clr");

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
